// File: rtl/ramp_soft_starter_if.sv
// rtl/ramp_soft_starter_if.sv - run/stop request inputs and drive level/status outputs of the soft starter
interface ramp_soft_starter_if #(
  parameter int LEVELS = 3,
  parameter int LW     = $clog2(LEVELS + 1)
);
  logic              ena;
  logic              rapido;
  logic              lento;
  logic              estop;
  logic [LEVELS-1:0] level_oh;
  logic [LW-1:0]     level;
  logic              running;
  logic              at_full;
  logic              tick;

  modport master (
    output ena, rapido, lento, estop,
    input  level_oh, level, running, at_full, tick
  );

  modport slave (
    input  ena, rapido, lento, estop,
    output level_oh, level, running, at_full, tick
  );
endinterface

// File: rtl/ramp_soft_starter.sv
// rtl/ramp_soft_starter.sv - prescaled soft-start ramp with ramp-down, emergency stop and global enable
module ramp_soft_starter #(
  parameter int CLK_DIV    = 4,
  parameter int LEVELS     = 3,
  parameter int DWELL_FAST = 2,
  parameter int DWELL_SLOW = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ramp_soft_starter_if.slave   io
);
  localparam int LW = $clog2(LEVELS + 1);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PMAX   = PW'(CLK_DIV - 1);
  localparam logic [LW-1:0] LTOP   = LW'(LEVELS);
  localparam logic [7:0]    DLIM_F = 8'(DWELL_FAST - 1);
  localparam logic [7:0]    DLIM_S = 8'(DWELL_SLOW - 1);

  typedef enum logic [1:0] {S_OFF, S_UP, S_FULL, S_DOWN} state_t;

  state_t            state, state_n;
  logic [LW-1:0]     level_q, level_n;
  logic [7:0]        dcnt, dcnt_n;
  logic [PW-1:0]     pcnt;
  logic [LEVELS-1:0] level_oh_q;
  logic              running_q;
  logic              at_full_q;
  logic              run;
  logic              tick;
  logic [7:0]        dlim;

  assign run  = io.rapido | io.lento;
  assign dlim = io.rapido ? DLIM_F : DLIM_S;
  // estop gating keeps the strobe quiet while the stop is held, even when CLK_DIV is 1
  assign tick = io.ena & ~io.estop & (pcnt == PMAX);

  function automatic logic [LEVELS-1:0] onehot(input logic [LW-1:0] l);
    logic [LEVELS-1:0] r;
    r = '0;
    for (int k = 1; k <= LEVELS; k++) begin
      if (l == LW'(k)) r[k-1] = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    state_n = state;
    level_n = level_q;
    dcnt_n  = dcnt;
    if (tick) begin
      case (state)
        S_OFF: begin
          if (run) begin
            state_n = S_UP;
            level_n = LW'(1);
            dcnt_n  = '0;
          end else begin
            level_n = '0;
          end
        end
        S_UP: begin
          if (!run) begin
            state_n = S_DOWN;
            dcnt_n  = '0;
          end else if (dcnt >= dlim) begin
            // >= so a slow-to-fast switch with dcnt already past the limit advances at once
            level_n = level_q + 1'b1;
            dcnt_n  = '0;
            if (level_n == LTOP) state_n = S_FULL;
          end else begin
            dcnt_n = dcnt + 8'd1;
          end
        end
        S_FULL: begin
          if (!run) state_n = S_DOWN;
          else      level_n = LTOP;
        end
        S_DOWN: begin
          if (run) begin
            state_n = S_UP;
            dcnt_n  = '0;
          end else begin
            level_n = level_q - 1'b1;
            if (level_n == '0) state_n = S_OFF;
          end
        end
        default: begin
          state_n = S_OFF;
          level_n = '0;
          dcnt_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_OFF;
      level_q    <= '0;
      dcnt       <= '0;
      pcnt       <= '0;
      level_oh_q <= '0;
      running_q  <= 1'b0;
      at_full_q  <= 1'b0;
    end else if (io.estop) begin
      state      <= S_OFF;
      level_q    <= '0;
      dcnt       <= '0;
      pcnt       <= '0;
      level_oh_q <= '0;
      running_q  <= 1'b0;
      at_full_q  <= 1'b0;
    end else if (io.ena) begin
      pcnt       <= tick ? '0 : pcnt + 1'b1;
      state      <= state_n;
      level_q    <= level_n;
      dcnt       <= dcnt_n;
      level_oh_q <= onehot(level_n);
      running_q  <= (state_n == S_UP) || (state_n == S_FULL);
      at_full_q  <= (state_n == S_FULL);
    end
  end

  assign io.level_oh = level_oh_q;
  assign io.level    = level_q;
  assign io.running  = running_q;
  assign io.at_full  = at_full_q;
  assign io.tick     = tick;
endmodule
